btn_pulse_conditioner: RTL and testbench

Upstream input stage for the PWM duty controller: synchronises and debounces the two raw duty-control buttons (increase, decrease) and converts each press into a single-cycle, mutually exclusive step pulse. The PWM generator consumes these pulses as its `duty_inc` / `duty_dec` requests, and so no longer needs internal debouncing. Optional auto-repeat emits further pulses while a button is held.

---
 rtl/pwm_ctrl_pkg.sv | 18 +
 rtl/btn_debounce_channel.sv | 123 ++++++++++++
 rtl/btn_pulse_conditioner.sv | 63 ++++++
 tb/tb_btn_pulse_conditioner.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM duty controller.
// Button states, duty step count and default debounce/repeat timing.
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HOLD,
    REPEAT
  } btn_state_t;

  localparam int PWM_DUTY_STEPS       = 10;
  localparam int DEBOUNCE_CYCLES_SIM  = 4;
  localparam int DEBOUNCE_CYCLES_FPGA = 1_250_000;
  localparam int HOLD_CYCLES_DEF      = 16;
  localparam int REPEAT_CYCLES_DEF    = 8;

endpackage

// File: rtl/btn_debounce_channel.sv
// One button: 2-FF sync, debounce, press FSM and optional repeat timer.
// Repeat timer and HOLD/REPEAT states exist only with BTN_AUTO_REPEAT_EN.
module btn_debounce_channel
  import pwm_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic d,
  output logic req
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2 ||
      REPEAT_CYCLES < 2) begin : g_param_check
    $error("btn_debounce_channel: cycle counts must be >= 2");
  end

  logic          sync1;
  logic          s;
  logic [CW-1:0] cnt;
  logic          settle;
  logic          rise;
  logic          fall;
  btn_state_t    state;

  assign settle = (s != d) &&
                  (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign rise   = settle & s;
  assign fall   = settle & ~s;

  // Two-flop synchroniser for the asynchronous raw button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= btn;
      s     <= sync1;
    end
  end

  // Accept a new level only after it has held for the full window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      d   <= 1'b0;
    end else if (s == d) begin
      cnt <= '0;
    end else if (settle) begin
      d   <= s;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                        HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = $clog2(TMAX);

  logic [TW-1:0] timer;

  // Press FSM: pulse on press, then hold delay, then periodic repeats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      req   <= 1'b0;
      timer <= '0;
    end else begin
      req <= 1'b0;
      if (fall) begin
        state <= IDLE;
        timer <= '0;
      end else if (rise && state == IDLE) begin
        state <= PRESSED;
        req   <= 1'b1;
        timer <= TW'(HOLD_CYCLES - 1);
      end else begin
        unique case (state)
          PRESSED: begin
            state <= HOLD;
            timer <= timer - TW'(1);
          end
          HOLD, REPEAT: begin
            if (timer == '0) begin
              state <= REPEAT;
              req   <= 1'b1;
              timer <= TW'(REPEAT_CYCLES - 1);
            end else begin
              timer <= timer - TW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end
`else
  // Press FSM: exactly one pulse per debounced press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      req   <= 1'b0;
    end else begin
      req <= 1'b0;
      if (fall) begin
        state <= IDLE;
      end else if (rise && state == IDLE) begin
        state <= PRESSED;
        req   <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/btn_pulse_conditioner.sv
// Debounced inc/dec buttons to exclusive one-cycle duty step pulses.
// Define BTN_AUTO_REPEAT_EN to add auto-repeat while a button is held.
module btn_pulse_conditioner
  import pwm_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic ui_increase_duty,
  input  logic ui_decrease_duty,
  output logic uo_duty_inc,
  output logic uo_duty_dec,
  output logic uo_inc_level,
  output logic uo_dec_level
);

  logic d_inc;
  logic d_dec;
  logic req_inc;
  logic req_dec;

  btn_debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) u_inc (
    .clk (clk),
    .rst (rst),
    .btn (ui_increase_duty),
    .d   (d_inc),
    .req (req_inc)
  );

  btn_debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) u_dec (
    .clk (clk),
    .rst (rst),
    .btn (ui_decrease_duty),
    .d   (d_dec),
    .req (req_dec)
  );

  assign uo_inc_level = d_inc;
  assign uo_dec_level = d_dec;

  // Drop a request while the other button is held down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uo_duty_inc <= 1'b0;
      uo_duty_dec <= 1'b0;
    end else begin
      uo_duty_inc <= req_inc & ~d_dec;
      uo_duty_dec <= req_dec & ~d_inc;
    end
  end

endmodule

// File: tb/tb_btn_pulse_conditioner.sv
// Bench for btn_pulse_conditioner: pulse scoreboard plus level checks.
// Repeat expectations follow BTN_AUTO_REPEAT_EN when defined.
module tb_btn_pulse_conditioner;

  localparam int DEB  = 4;
  localparam int HOLD = 16;
  localparam int REP  = 8;

  typedef struct {
    int cyc;
    bit ch;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ui_increase_duty = 1'b0;
  logic ui_decrease_duty = 1'b0;
  logic uo_duty_inc;
  logic uo_duty_dec;
  logic uo_inc_level;
  logic uo_dec_level;

  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  exp_t sb[$];

  btn_pulse_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLD),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ui_increase_duty (ui_increase_duty),
    .ui_decrease_duty (ui_decrease_duty),
    .uo_duty_inc      (uo_duty_inc),
    .uo_duty_dec      (uo_duty_dec),
    .uo_inc_level     (uo_inc_level),
    .uo_dec_level     (uo_dec_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (uo_duty_inc || uo_duty_dec)) begin
      exp_t e;
      bit   ch;
      ch = uo_duty_dec && !uo_duty_inc;
      total++;
      if (uo_duty_inc && uo_duty_dec)
        $display("FAIL exclusive cyc=%0d inc=1 dec=1 required not both",
                 cyc);
      else
        passed++;
      total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_pulse cyc=%0d ch=%0d required none",
                 cyc, ch);
      end else begin
        e = sb.pop_front();
        if (e.cyc !== cyc || e.ch !== ch)
          $display("FAIL pulse cyc=%0d ch=%0d required cyc=%0d ch=%0d",
                   cyc, ch, e.cyc, e.ch);
        else
          passed++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_drained(input string name);
    total++;
    if (sb.size() !== 0)
      $display("FAIL %s_missing pending=%0d required 0",
               name, sb.size());
    else
      passed++;
    sb.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(3);
    total++;
    if ({uo_duty_inc, uo_duty_dec, uo_inc_level, uo_dec_level} !== 4'b0)
      $display("FAIL reset_outs got=%b required 0000",
               {uo_duty_inc, uo_duty_dec, uo_inc_level, uo_dec_level});
    else
      passed++;
    rst = 1'b0;
    idle(5);
    total++;
    if ({uo_duty_inc, uo_duty_dec, uo_inc_level, uo_dec_level} !== 4'b0)
      $display("FAIL post_reset_outs got=%b required 0000",
               {uo_duty_inc, uo_duty_dec, uo_inc_level, uo_dec_level});
    else
      passed++;
  endtask

  task automatic test_clean_press;
    int c;
    c = cyc;
    ui_increase_duty = 1'b1;
    sb.push_back('{c + DEB + 3, 1'b0});
    idle(DEB + 1);
    total++;
    if (uo_inc_level !== 1'b0)
      $display("FAIL press_level_early got=%b required 0", uo_inc_level);
    else
      passed++;
    idle(1);
    total++;
    if (uo_inc_level !== 1'b1)
      $display("FAIL press_level_rise got=%b required 1", uo_inc_level);
    else
      passed++;
    idle(20 - DEB - 2);
    ui_increase_duty = 1'b0;
    idle(DEB + 1);
    total++;
    if (uo_inc_level !== 1'b1)
      $display("FAIL release_level_early got=%b required 1",
               uo_inc_level);
    else
      passed++;
    idle(1);
    total++;
    if (uo_inc_level !== 1'b0)
      $display("FAIL release_level got=%b required 0", uo_inc_level);
    else
      passed++;
    idle(10);
    expect_drained("clean_press");
  endtask

  task automatic test_bounce;
    int c;
    c = cyc;
    ui_decrease_duty = 1'b1; idle(1);
    ui_decrease_duty = 1'b0; idle(1);
    ui_decrease_duty = 1'b1; idle(1);
    ui_decrease_duty = 1'b0; idle(1);
    ui_decrease_duty = 1'b1;
    sb.push_back('{c + 4 + DEB + 3, 1'b1});
    idle(DEB + 1);
    total++;
    if (uo_dec_level !== 1'b0)
      $display("FAIL bounce_level_early got=%b required 0", uo_dec_level);
    else
      passed++;
    idle(10 - DEB - 1);
    ui_decrease_duty = 1'b0;
    idle(15);
    expect_drained("bounce");
  endtask

  task automatic test_glitch_boundary;
    ui_increase_duty = 1'b1;
    idle(DEB - 1);
    ui_increase_duty = 1'b0;
    idle(12);
    total++;
    if (uo_inc_level !== 1'b0)
      $display("FAIL glitch_level got=%b required 0", uo_inc_level);
    else
      passed++;
    expect_drained("glitch");
    sb.push_back('{cyc + DEB + 3, 1'b0});
    ui_increase_duty = 1'b1;
    idle(DEB);
    ui_increase_duty = 1'b0;
    idle(3);
    total++;
    if (uo_inc_level !== 1'b1)
      $display("FAIL min_width_level got=%b required 1", uo_inc_level);
    else
      passed++;
    idle(15);
    expect_drained("min_width");
  endtask

  task automatic test_simultaneous;
    ui_increase_duty = 1'b1;
    ui_decrease_duty = 1'b1;
    idle(DEB + 2);
    total++;
    if ({uo_inc_level, uo_dec_level} !== 2'b11)
      $display("FAIL simul_levels got=%b required 11",
               {uo_inc_level, uo_dec_level});
    else
      passed++;
    idle(30 - DEB - 2);
    ui_increase_duty = 1'b0;
    ui_decrease_duty = 1'b0;
    idle(15);
    expect_drained("simultaneous");
  endtask

  task automatic test_hold_other;
    ui_decrease_duty = 1'b1;
    sb.push_back('{cyc + DEB + 3, 1'b1});
    idle(12);
    ui_increase_duty = 1'b1;
    idle(15);
    total++;
    if (uo_inc_level !== 1'b1)
      $display("FAIL other_inc_level got=%b required 1", uo_inc_level);
    else
      passed++;
    ui_increase_duty = 1'b0;
    ui_decrease_duty = 1'b0;
    idle(15);
    expect_drained("hold_other");
  endtask

  task automatic test_hold_repeat;
    int c;
    int f;
    int p;
    int h;
    h = 42;
    c = cyc;
    f = c + h + DEB + 2;
    p = c + DEB + 3;
    sb.push_back('{p, 1'b0});
`ifdef BTN_AUTO_REPEAT_EN
    p = p + HOLD;
    while (p <= f) begin
      sb.push_back('{p, 1'b0});
      p = p + REP;
    end
`endif
    ui_increase_duty = 1'b1;
    idle(h);
    ui_increase_duty = 1'b0;
    idle(20);
    expect_drained("hold_repeat");
  endtask

  task automatic test_reset_mid_press;
    int r;
    ui_increase_duty = 1'b1;
    sb.push_back('{cyc + DEB + 3, 1'b0});
    idle(DEB + 2);
    idle(2);
    rst = 1'b1;
    sb.delete();
    #1;
    total++;
    if ({uo_duty_inc, uo_duty_dec, uo_inc_level, uo_dec_level} !== 4'b0)
      $display("FAIL midreset_outs got=%b required 0000",
               {uo_duty_inc, uo_duty_dec, uo_inc_level, uo_dec_level});
    else
      passed++;
    idle(3);
    total++;
    if ({uo_duty_inc, uo_duty_dec, uo_inc_level, uo_dec_level} !== 4'b0)
      $display("FAIL midreset_hold got=%b required 0000",
               {uo_duty_inc, uo_duty_dec, uo_inc_level, uo_dec_level});
    else
      passed++;
    r = cyc;
    rst = 1'b0;
    sb.push_back('{r + DEB + 3, 1'b0});
    idle(DEB + 1);
    total++;
    if (uo_inc_level !== 1'b0)
      $display("FAIL midreset_relatch got=%b required 0", uo_inc_level);
    else
      passed++;
    idle(8);
    ui_increase_duty = 1'b0;
    idle(15);
    expect_drained("reset_mid_press");
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch_boundary();
    test_simultaneous();
    test_hold_other();
    test_hold_repeat();
    test_reset_mid_press();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
